// File: rtl/usb_buf_pkg.sv
// Shared constants, helper function and op-decode type for the USB endpoint packet buffer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package usb_buf_pkg;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_WIDTH = 8;

  // Occupancy counts must reach DEPTH itself, hence one extra bit over the pointer width.
  function automatic int clog2_occ(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [2:0] {
    NONE,
    WR_TX,
    WR_RX,
    RD_TX,
    RD_RX
  } buf_op_t;

endpackage

// File: rtl/usb_pkt_buffer_if.sv
// Control/data bundle between the AHB/protocol side and the endpoint packet buffer.
// Latency: n/a (wires only).
// Backpressure: none; the buffer reports full/empty and sticky errors instead of stalling.
interface usb_pkt_buffer_if #(
  parameter int DEPTH = usb_buf_pkg::DEF_DEPTH,
  parameter int WIDTH = usb_buf_pkg::DEF_WIDTH
);
  import usb_buf_pkg::*;

  localparam int OCC_W = clog2_occ(DEPTH);

  logic             clear;
  logic             flush;
  logic             store_tx_data;
  logic [WIDTH-1:0] tx_data;
  logic             store_rx_data;
  logic [WIDTH-1:0] rx_packet_data;
  logic             get_tx_data;
  logic             get_rx_data;
  logic             pkt_commit;
  logic             pkt_discard;
  logic [OCC_W-1:0] buff_occ;
  logic [OCC_W-1:0] avail_cnt;
  logic [WIDTH-1:0] tx_packet_data;
  logic [WIDTH-1:0] rx_data;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output clear, flush, store_tx_data, tx_data, store_rx_data, rx_packet_data,
           get_tx_data, get_rx_data, pkt_commit, pkt_discard,
    input  buff_occ, avail_cnt, tx_packet_data, rx_data, full, empty,
           overflow_err, underflow_err
  );

  modport slave (
    input  clear, flush, store_tx_data, tx_data, store_rx_data, rx_packet_data,
           get_tx_data, get_rx_data, pkt_commit, pkt_discard,
    output buff_occ, avail_cnt, tx_packet_data, rx_data, full, empty,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/buf_ptr_ctrl.sv
// Write/read/checkpoint pointers, occupancy counts, full/empty and sticky errors.
// Latency: pointers and counts update on the edge after the request; flags are combinational from them.
// Backpressure: none; writes while full and reads while empty are dropped and flagged.
module buf_ptr_ctrl
  import usb_buf_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = clog2_occ(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             flush,
  input  logic             store_tx,
  input  logic             store_rx,
  input  logic             get_tx,
  input  logic             get_rx,
  input  logic             commit,
  input  logic             discard,
  output buf_op_t          wr_op,
  output buf_op_t          rd_op,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic             rd_en,
  output logic [PTR_W-1:0] rd_addr,
  output logic [OCC_W-1:0] buff_occ,
  output logic [OCC_W-1:0] avail_cnt,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, chk_ptr_q, chk_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d, avail_q, avail_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Priority decode: RX store beats TX store, TX get beats RX get; clear/flush swallow both.
  always_comb begin
    wr_op = NONE;
    rd_op = NONE;
    if (!clear && !flush) begin
      if (store_rx)      wr_op = WR_RX;
      else if (store_tx) wr_op = WR_TX;
      if (get_tx)        rd_op = RD_TX;
      else if (get_rx)   rd_op = RD_RX;
    end
  end

  // Next pointer/count/error state. Full is judged before this cycle's read, so a
  // write into a full buffer is accepted only when a committed entry leaves alongside it.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    chk_ptr_d = chk_ptr_q;
    occ_d     = occ_q;
    avail_d   = avail_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rd_ok     = (rd_op != NONE) && (avail_q != '0);
    wr_ok     = (wr_op != NONE) && !discard && (!full || rd_ok);
    if (clear || flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      chk_ptr_d = '0;
      occ_d     = '0;
      avail_d   = '0;
      if (clear) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
    end else begin
      if ((rd_op != NONE) && !rd_ok) udf_d = 1'b1;
      if ((wr_op != NONE) && !discard && full && !rd_ok) ovf_d = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_ok);
      if (discard) begin
        // Pending entries vanish: what remains is exactly the committed region.
        wr_ptr_d = chk_ptr_q;
        occ_d    = avail_q - OCC_W'(rd_ok);
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        occ_d    = occ_q + OCC_W'(wr_ok) - OCC_W'(rd_ok);
      end
      if (commit && !discard) begin
        chk_ptr_d = wr_ptr_d;
        avail_d   = occ_d;
      end else begin
        avail_d   = avail_q - OCC_W'(rd_ok);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      chk_ptr_q <= '0;
      occ_q     <= '0;
      avail_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      chk_ptr_q <= chk_ptr_d;
      occ_q     <= occ_d;
      avail_q   <= avail_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign wr_en         = wr_ok;
  assign wr_addr       = wr_ptr_q;
  assign rd_en         = rd_ok;
  assign rd_addr       = rd_ptr_q;
  assign buff_occ      = occ_q;
  assign avail_cnt     = avail_q;
  assign full          = (occ_q == OCC_W'(DEPTH));
  assign empty         = (avail_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: rtl/usb_pkt_buffer.sv
// Circular endpoint buffer shared by host TX and USB RX paths, with packet commit/discard.
// Latency: read data appears on tx_packet_data/rx_data one edge after the get.
// Backpressure: none; overflow/underflow are dropped and latched as sticky errors.
module usb_pkt_buffer
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            n_rst,
  usb_pkt_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  buf_op_t          wr_op, rd_op;
  logic             wr_en, rd_en;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0] wr_dat, rd_dat;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d;

  buf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (bus.clear),
    .flush         (bus.flush),
    .store_tx      (bus.store_tx_data),
    .store_rx      (bus.store_rx_data),
    .get_tx        (bus.get_tx_data),
    .get_rx        (bus.get_rx_data),
    .commit        (bus.pkt_commit),
    .discard       (bus.pkt_discard),
    .wr_op         (wr_op),
    .rd_op         (rd_op),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .buff_occ      (bus.buff_occ),
    .avail_cnt     (bus.avail_cnt),
    .full          (bus.full),
    .empty         (bus.empty),
    .overflow_err  (bus.overflow_err),
    .underflow_err (bus.underflow_err)
  );

  assign wr_dat = (wr_op == WR_RX) ? bus.rx_packet_data : bus.tx_data;
  assign rd_dat = mem[rd_addr];

  // Storage: no reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Read output next state: only the selected output loads; clear zeroes both.
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (bus.clear) begin
      tx_d = '0;
      rx_d = '0;
    end else if (rd_en) begin
      if (rd_op == RD_TX) tx_d = rd_dat;
      else                rx_d = rd_dat;
    end
  end

  // Registered read outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign bus.tx_packet_data = tx_q;
  assign bus.rx_data        = rx_q;

endmodule

// File: tb/tb_usb_pkt_buffer.sv
// Scoreboard bench for usb_pkt_buffer: queue-based reference model, directed plan then random traffic.
// Latency: expected state is pushed at stimulus time and checked 1 unit after the following edge.
// Backpressure: n/a.
module tb_usb_pkt_buffer;

  localparam int DEPTH = 64;
  localparam int WIDTH = 8;

  typedef struct {
    bit       clr, fl, stx, srx, gtx, grx, com, dis;
    logic [7:0] txd, rxd;
  } op_t;

  typedef struct {
    int         occ, avail;
    bit         full, empty, ovf, udf;
    logic [7:0] tx, rx;
  } exp_t;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  usb_pkt_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  usb_pkt_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: committed and pending entries as plain queues.
  logic [7:0] m_com[$];
  logic [7:0] m_pend[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_tx, m_rx;
  exp_t       exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic cmp_state(input exp_t e);
    chk("buff_occ",      32'(bus.buff_occ),      32'(e.occ));
    chk("avail_cnt",     32'(bus.avail_cnt),     32'(e.avail));
    chk("full",          32'(bus.full),          32'(e.full));
    chk("empty",         32'(bus.empty),         32'(e.empty));
    chk("overflow_err",  32'(bus.overflow_err),  32'(e.ovf));
    chk("underflow_err", 32'(bus.underflow_err), 32'(e.udf));
    chk("tx_packet_data",32'(bus.tx_packet_data),32'(e.tx));
    chk("rx_data",       32'(bus.rx_data),       32'(e.rx));
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.occ   = m_com.size() + m_pend.size();
    e.avail = m_com.size();
    e.full  = (e.occ == DEPTH);
    e.empty = (e.avail == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.tx    = m_tx;
    e.rx    = m_rx;
    return e;
  endfunction

  task automatic model_reset();
    m_com.delete();
    m_pend.delete();
    m_ovf = 0;
    m_udf = 0;
    m_tx  = '0;
    m_rx  = '0;
  endtask

  task automatic model_step(input op_t o);
    int         occ;
    bit         rd_req, rdv, wr_req;
    logic [7:0] wd;
    if (o.clr || o.fl) begin
      m_com.delete();
      m_pend.delete();
      if (o.clr) begin
        m_ovf = 0;
        m_udf = 0;
        m_tx  = '0;
        m_rx  = '0;
      end
      return;
    end
    occ    = m_com.size() + m_pend.size();
    rd_req = o.gtx || o.grx;
    rdv    = rd_req && (m_com.size() > 0);
    if (rd_req && !rdv) m_udf = 1;
    if (rdv) begin
      if (o.gtx) m_tx = m_com.pop_front();
      else       m_rx = m_com.pop_front();
    end
    wr_req = o.stx || o.srx;
    wd     = o.srx ? o.rxd : o.txd;
    if (o.dis) begin
      m_pend.delete();
    end else begin
      if (wr_req) begin
        if (occ < DEPTH || rdv) m_pend.push_back(wd);
        else                    m_ovf = 1;
      end
      if (o.com) begin
        foreach (m_pend[i]) m_com.push_back(m_pend[i]);
        m_pend.delete();
      end
    end
  endtask

  task automatic drive(input op_t o);
    bus.clear          = o.clr;
    bus.flush          = o.fl;
    bus.store_tx_data  = o.stx;
    bus.tx_data        = o.txd;
    bus.store_rx_data  = o.srx;
    bus.rx_packet_data = o.rxd;
    bus.get_tx_data    = o.gtx;
    bus.get_rx_data    = o.grx;
    bus.pkt_commit     = o.com;
    bus.pkt_discard    = o.dis;
  endtask

  // One clock of stimulus: drive on the falling edge, push the model's post-edge view.
  task automatic run(input op_t o);
    @(negedge clk);
    drive(o);
    model_step(o);
    exp_q.push_back(snap());
  endtask

  function automatic op_t idle();
    op_t o;
    o = '{default: '0};
    return o;
  endfunction

  task automatic st(input bit use_rx, input logic [7:0] d, input bit com = 0);
    op_t o = idle();
    if (use_rx) begin o.srx = 1; o.rxd = d; end
    else        begin o.stx = 1; o.txd = d; end
    o.com = com;
    run(o);
  endtask

  task automatic rd(input bit use_tx);
    op_t o = idle();
    if (use_tx) o.gtx = 1;
    else        o.grx = 1;
    run(o);
  endtask

  task automatic ctl(input bit clr, input bit fl, input bit com, input bit dis);
    op_t o = idle();
    o.clr = clr; o.fl = fl; o.com = com; o.dis = dis;
    run(o);
  endtask

  // Asynchronous reset between edges; checked immediately, without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    cmp_state(snap());
    drive(idle());
    n_rst = 1'b1;
  endtask

  // Monitor: every cycle that had stimulus has one expected state waiting.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_state(e);
    end
  end

  initial begin
    op_t o;
    drive(idle());
    model_reset();
    #2;
    cmp_state(snap());
    #10;
    n_rst = 1'b1;

    // Reset mid-traffic, then a get on the emptied buffer.
    for (int i = 0; i < 5; i++) st(1, 8'($urandom), (i == 4));
    async_reset();
    rd(0);
    ctl(1, 0, 0, 0);

    // Commit then read back through the TX output.
    st(0, 8'h11); st(0, 8'h22); st(0, 8'h33);
    ctl(0, 0, 1, 0);
    rd(1); rd(1); rd(1);
    run(idle());

    // Discard rolls back to the checkpoint, dropping a same-cycle store.
    st(0, 8'hA0); st(0, 8'hA1, 1);
    for (int i = 0; i < 4; i++) st(1, 8'hB0 + 8'(i));
    o = idle(); o.dis = 1; o.stx = 1; o.txd = 8'hCC;
    run(o);
    rd(1); rd(0); rd(0);
    ctl(1, 0, 0, 0);

    // Fill, full-with-read, overflow, wrap.
    for (int i = 0; i < DEPTH; i++) st(0, 8'(i), (i == DEPTH - 1));
    o = idle(); o.srx = 1; o.rxd = 8'hEE; o.grx = 1;
    run(o);
    st(0, 8'h40);
    for (int i = 0; i < 10; i++) rd(1);
    for (int i = 0; i < 10; i++) st(0, 8'(64 + i), (i == 9));
    for (int i = 0; i < DEPTH; i++) rd(i[0]);
    o = idle(); o.stx = 1; o.txd = 8'h55; o.srx = 1; o.rxd = 8'h66; o.com = 1;
    run(o);
    rd(0);

    // Flush keeps errors, clear wipes them and the outputs.
    for (int i = 0; i < 7; i++) st(1, 8'h70 + 8'(i), (i == 6));
    rd(0);
    ctl(0, 1, 0, 0);
    run(idle());
    ctl(1, 0, 0, 0);
    run(idle());

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      o = idle();
      o.clr = ($urandom_range(0, 149) == 0);
      o.fl  = ($urandom_range(0, 99) == 0);
      o.stx = ($urandom_range(0, 1) == 0);
      o.srx = ($urandom_range(0, 3) == 0);
      o.gtx = ($urandom_range(0, 3) == 0);
      o.grx = ($urandom_range(0, 3) == 0);
      o.com = ($urandom_range(0, 5) == 0);
      o.dis = ($urandom_range(0, 19) == 0);
      o.txd = 8'($urandom);
      o.rxd = 8'($urandom);
      run(o);
    end

    drive(idle());
    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain cyc=%0d got=%0d pending want=0", cyc, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_pkt_buffer.md
Name: usb_pkt_buffer

Overview:
- Parametrised next-generation USB endpoint data buffer: one circular store shared by the host-side TX path and the USB-side RX path, sitting between the AHB-lite slave and the protocol TX/RX controllers.
- Adds packet checkpointing (commit/discard, so a CRC-failed RX packet is rolled back), committed-only reads, full/empty flags and sticky overflow/underflow errors.
- Depth and data width are generic.

Parameters:
- DEPTH, 64, number of storage entries; power of two, 4..256.
- WIDTH, 8, bits per entry.
- OCC_W, $clog2(DEPTH+1), width of the occupancy counts; derived, never overridden.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  empty the buffer and clear the sticky errors.
- flush  in  1  empty the buffer; sticky errors are kept.
- store_tx_data  in  1  write tx_data (host side).
- tx_data  in  WIDTH  host write data.
- store_rx_data  in  1  write rx_packet_data (USB side).
- rx_packet_data  in  WIDTH  RX controller write data.
- get_tx_data  in  1  pop one entry to tx_packet_data.
- get_rx_data  in  1  pop one entry to rx_data.
- pkt_commit  in  1  make all pending entries readable.
- pkt_discard  in  1  roll the write pointer back to the last commit.
- buff_occ  out  OCC_W  total entries, committed plus pending.
- avail_cnt  out  OCC_W  committed, readable entries.
- tx_packet_data  out  WIDTH  registered TX read data.
- rx_data  out  WIDTH  registered RX read data.
- full  out  1  buff_occ == DEPTH.
- empty  out  1  avail_cnt == 0.
- overflow_err  out  1  sticky: write attempted while full.
- underflow_err  out  1  sticky: read attempted while empty.

Behaviour:
- Reset and clear: on n_rst low, asynchronously, all pointers, counts, data outputs and errors go to 0, and empty=1. Storage contents are don't-care.
- Pointers: wr_ptr, rd_ptr and chk_ptr (the checkpoint) are log2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
- buff_occ = wr_ptr - rd_ptr (count-tracked so that full is distinguished from empty). avail_cnt = chk_ptr - rd_ptr, likewise count-tracked.
- Priority within one cycle, highest first: clear > flush > pkt_discard > writes/commit > reads.
- Write select: store_rx_data beats store_tx_data; if both are asserted, only rx_packet_data is written. A write stores at wr_ptr and increments it.
- Write while full (before this cycle's read): the write is dropped and overflow_err is set. A write is legal while full if a valid read occurs in the same cycle.
- Read select: get_tx_data beats get_rx_data. A read on avail_cnt > 0 loads the entry at rd_ptr into the selected output register on the next edge (1-cycle latency). The other output holds its value and rd_ptr increments.
- Read while avail_cnt == 0: no pointer change, the output holds, and underflow_err is set. Reads never consume pending (uncommitted) entries.
- pkt_commit: chk_ptr takes the post-write wr_ptr, so a word written in the same cycle is committed.
- pkt_discard: wr_ptr := chk_ptr, and any same-cycle write is dropped without error. pkt_commit asserted with pkt_discard is ignored.
- flush: wr_ptr, rd_ptr and chk_ptr all go to 0. Data outputs and errors hold. Any same-cycle store, get or commit is ignored.
- clear: as flush, and additionally zeroes tx_packet_data, rx_data, overflow_err and underflow_err.
- Simultaneous valid read and write: buff_occ is unchanged. If the same cycle also commits, avail_cnt changes by +pending-1.
- full and empty are combinational from the registered counts. buff_occ and avail_cnt update on the edge following the event.
- Errors stay asserted until clear or reset.

Decomposition:
- Package usb_buf_pkg holds:
  - default DEPTH and WIDTH constants;
  - the function clog2_occ;
  - the typedef buf_op_t (enum: NONE, WR_TX, WR_RX, RD_TX, RD_RX) used for the priority decode.
- One sub-module, buf_ptr_ctrl, holds the three pointers, both counts, full/empty and the sticky errors. It outputs wr_en, wr_addr, rd_en and rd_addr.
- The top level holds the storage array, the write mux and the two registered read outputs.

Test Plan (DEPTH=64, WIDTH=8):
- Reset mid-traffic: store 5 RX bytes and commit, then pulse n_rst low between edges. Immediately buff_occ=0, avail_cnt=0, empty=1 and the outputs are 0; after release, a get_rx_data sets underflow_err=1.
- Commit/read: store 0x11,0x22,0x33 via store_tx_data, then pkt_commit. Three get_tx_data return tx_packet_data 0x11,0x22,0x33, each one cycle after its get; the counts then read 0.
- Discard: commit 2 bytes (0xA0,0xA1), store 4 more, then pkt_discard with a simultaneous store. Result buff_occ=2, avail_cnt=2; reads return 0xA0,0xA1, and a further read sets underflow_err.
- Full/wrap: write 64 bytes (value=index) and commit; full=1. A 65th store sets overflow_err and buff_occ stays 64. Read 10, write 10 more (wrapping) and commit; all 64 read back in order 10..63, 64..73.
- Simultaneous events: with full=1, store_rx_data+get_rx_data in the same cycle leaves buff_occ=64 with no overflow. store_tx_data+store_rx_data together writes only the RX byte.
- flush vs clear: with overflow_err=1 and 7 bytes stored, flush gives buff_occ=0 with overflow_err still 1. A subsequent clear gives overflow_err=0 and rx_data=0.
